bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter using the reverse double-dabble algorithm: shift right, then subtract 3 from every BCD nibble that is 8 or more.
- It is the companion of the team's sequential binary-to-BCD converter.
- It takes a parallel packed-BCD word, produces the unsigned binary value one bit per clock, and reports it with a start/ready/done handshake.
- It sits between BCD entry or display logic and the binary datapath.

Parameters:
- DIGITS, 3, number of BCD digits at the input.
- BIN_W, 10, width of the binary result. Required: 2^BIN_W > 10^DIGITS - 1. Violation is an elaboration-time error.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only while ready=1.
- bcd_in  input  4*DIGITS  packed BCD; nibble 0 (bits 3:0) is the units digit.
- ready  output  1  high in IDLE only.
- busy  output  1  high in CONVERT only.
- done  output  1  one-cycle pulse: result and err are valid.
- bin_out  output  BIN_W  binary result; held until the next accepted start.
- err  output  1  last accepted input contained a digit greater than 9; held like bin_out.

Behaviour:
- Reset (synchronous, any state including mid-conversion):
  - state=IDLE, ready=1, busy=0, done=0, bin_out=0, err=0.
  - Shift register and counter are cleared.
  - An in-flight conversion is abandoned with no done pulse.
- States: IDLE, CONVERT, DONE. All outputs are registered or decoded from the state.
- IDLE, start=1 at edge E0:
  - bcd_in is captured.
  - If any nibble > 9: go to DONE, err<=1, bin_out<=0. No CONVERT cycles.
  - Otherwise: working register W (4*DIGITS + BIN_W bits) <= {bcd_in, BIN_W'b0}, count<=0, err<=0, go to CONVERT.
  - bin_out keeps its old value until the new result is written.
- CONVERT, each edge:
  - W <= W >> 1 (a zero enters the MSB). The LSB of the BCD field moves into the MSB of the binary field.
  - Then each shifted BCD nibble that is >= 8 has 3 subtracted, using 4-bit arithmetic with no borrow between nibbles.
  - count increments.
- After the BIN_W-th shift edge (count reaches BIN_W):
  - bin_out <= binary field of the shifted and corrected W.
  - Go to DONE.
  - The BCD field is then all zero; no extra cycle is needed.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE unconditionally.
  - start is ignored in DONE.
- Latency:
  - Valid input: accepted at E0, done high in the cycle after edge E0+BIN_W. That is BIN_W+1 edges; 11 with the defaults.
  - Invalid input: done high in the cycle after E0.
  - Throughput: one conversion per BIN_W+2 cycles when start is held high.
- Simultaneous events:
  - start while busy or in DONE is ignored; no queuing.
  - bcd_in changing during CONVERT has no effect.
  - reset together with start: reset wins.
- A start=1 held continuously restarts a conversion on the first IDLE cycle after DONE.

Test Plan:
- reset, then bcd_in=12'h255, start pulse -> busy for 10 cycles; done in the 11th cycle after acceptance; bin_out=10'b0011111111 (255); err=0.
- bcd_in=12'h999 -> bin_out=999 (10'b1111100111).
- bcd_in=12'h000 -> bin_out=0.
- bcd_in=12'h001 -> bin_out=1.
- bcd_in=12'h1A3 -> done one cycle after acceptance; err=1; bin_out=0; busy never asserted.
- Next conversion after the invalid input: bcd_in=12'h042 -> err clears; bin_out=42.
- start held high with bcd_in=12'h128, then 12'h064 -> back-to-back results 128 and 64; done pulses 12 cycles apart.
- Changing bcd_in and pulsing start mid-conversion has no effect on the running result.
- reset asserted at shift cycle 5 of a 12'h777 conversion -> next cycle ready=1, bin_out=0, no done pulse.
- Fresh 12'h777 after that reset -> bin_out=777.

Source files
------------

// File: rtl/bcd_to_binary_seq_if.sv
// rtl/bcd_to_binary_seq_if.sv - start/ready/done handshake bundle for bcd_to_binary_seq
//
// Purpose: groups the request and result signals of the BCD-to-binary
// converter so that the producer and the converter share one port.
// Signals:
//   start    request a conversion (sampled only while ready=1)
//   bcd_in   packed BCD, nibble 0 = units digit
//   ready    converter idle, able to accept start
//   busy     conversion in progress
//   done     one-cycle pulse, bin_out/err valid
//   bin_out  unsigned binary result, held until the next accepted start
//   err      last accepted input held a digit greater than 9
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  ready, busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output ready, busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter (reverse double-dabble)
//
// Purpose: converts a packed BCD word into an unsigned binary value, one
// result bit per clock. Each step shifts the working register right by one
// and then subtracts 3 from every BCD nibble that reads 8 or more.
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous, active-high reset (abandons any conversion silently)
//   bus    bcd_to_binary_seq_if.slave: start, bcd_in in; ready, busy, done,
//          bin_out, err out
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  bcd_to_binary_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int W_W   = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  localparam longint MAX_DEC   = (64'd10 ** DIGITS) - 64'd1;
  localparam longint BIN_RANGE = 64'd1 << BIN_W;

  // The result field must hold the largest decimal value the digits can express.
  generate
    if (BIN_RANGE <= MAX_DEC) begin : g_width_check
      $error("bcd_to_binary_seq: BIN_W too small for DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  logic [W_W-1:0]     r_work;    // {bcd field, binary field}
  logic [CNT_W-1:0]   r_count;
  logic [BIN_W-1:0]   r_bin_out;
  logic               r_err;

  logic [W_W-1:0]     w_shifted;
  logic [W_W-1:0]     w_corrected;
  logic               w_bad_digit;

  always_comb begin
    w_shifted   = r_work >> 1;
    w_corrected = w_shifted;
    // A nibble >= 8 after the shift had an odd weight-10 bit move in from
    // above; 4-bit subtract of 3 turns that 8 back into 5 (i.e. 10/2).
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shifted[BIN_W + 4*d + 3]) begin
        w_corrected[BIN_W + 4*d +: 4] = w_shifted[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9) begin
        w_bad_digit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_count   <= '0;
      r_bin_out <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_bad_digit) begin
              r_err     <= 1'b1;
              r_bin_out <= '0;
              r_state   <= S_DONE;
            end else begin
              r_work  <= {bus.bcd_in, {BIN_W{1'b0}}};
              r_count <= '0;
              r_err   <= 1'b0;
              r_state <= S_CONVERT;
            end
          end
        end
        S_CONVERT: begin
          r_work  <= w_corrected;
          r_count <= r_count + CNT_W'(1);
          // The BCD field is empty after the last shift, so the binary
          // field of this step is already the final result.
          if (r_count == LAST_CNT) begin
            r_bin_out <= w_corrected[BIN_W-1:0];
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready   = (r_state == S_IDLE);
  assign bus.busy    = (r_state == S_CONVERT);
  assign bus.done    = (r_state == S_DONE);
  assign bus.bin_out = r_bin_out;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - directed self-checking bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;
  int last_bin;

  bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge with the DUT idle. Returns at a falling edge
  // with the DUT idle again after the DONE cycle.
  task automatic run_conv(input string tag, input logic [11:0] bcd, input int exp_bin,
                          input bit exp_err, input int exp_lat, input bit disturb);
    int  lat;
    int  nbusy;
    bit  seen;
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(negedge clk);
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    seen  = 0;
    if (exp_lat > 1) chk({tag, "_hold"}, 32'(bus.bin_out), 32'(last_bin));
    while (!seen && lat <= 30) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        if (bus.busy) begin
          nbusy++;
          if (disturb) begin
            bus.start  = 1'b1;
            bus.bcd_in = 12'h999;
          end
        end
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
    chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    // start may still be high in DONE; it must be ignored there.
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_back_idle"}, 32'(bus.ready), 32'd1);
    last_bin = exp_bin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gap;
    bit seen;
    n_checks   = 0;
    n_fail     = 0;
    last_bin   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_bin",   32'(bus.bin_out), 32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);

    run_conv("c255", 12'h255, 255, 1'b0, 11, 1'b0);
    run_conv("c999", 12'h999, 999, 1'b0, 11, 1'b0);
    run_conv("c000", 12'h000, 0,   1'b0, 11, 1'b0);
    run_conv("c001", 12'h001, 1,   1'b0, 11, 1'b0);
    run_conv("c1A3", 12'h1A3, 0,   1'b1, 1,  1'b0);
    run_conv("c042", 12'h042, 42,  1'b0, 11, 1'b0);
    run_conv("c314_disturb", 12'h314, 314, 1'b0, 11, 1'b1);

    // Back-to-back with start held high.
    bus.start  = 1'b1;
    bus.bcd_in = 12'h128;
    seen = 0;
    for (cyc = 0; cyc < 30 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("b2b_first_done", 32'(seen), 32'd1);
    chk("b2b_first_bin", 32'(bus.bin_out), 32'd128);
    bus.bcd_in = 12'h064;
    seen = 0;
    gap  = 0;
    while (!seen && gap < 30) begin
      @(negedge clk);
      gap++;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    chk("b2b_gap", seen ? 32'(gap) : 32'hFFFF_FFFF, 32'd12);
    chk("b2b_second_bin", 32'(bus.bin_out), 32'd64);
    @(negedge clk);
    chk("b2b_idle", 32'(bus.ready), 32'd1);

    // Reset in the middle of a 777 conversion.
    bus.start  = 1'b1;
    bus.bcd_in = 12'h777;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_busy",  32'(bus.busy),  32'd0);
    chk("mid_rst_bin",   32'(bus.bin_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) seen = 1;
      @(negedge clk);
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);

    // Reset together with start: reset wins.
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.bcd_in = 12'h555;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_ready", 32'(bus.ready), 32'd1);
    chk("rst_start_busy",  32'(bus.busy),  32'd0);

    last_bin = 0;
    run_conv("c777", 12'h777, 777, 1'b0, 11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
